// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request and data-memory bus bundle for load_store_unit
// Ports (master = load_store_unit, slave = core/memory environment):
//   core -> lsu : start, is_store, funct3[2:0], addr[ADDR_W], wdata[32]
//   lsu -> core : busy, done, rdata[32], bus_err, misalign
//   lsu -> mem  : mem_req, mem_we, mem_be[4], mem_addr[ADDR_W], mem_wdata[32]
//   mem -> lsu  : mem_ready, mem_rdata[32]
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic              is_store;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic              bus_err;
    logic              misalign;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (
        input  start, is_store, funct3, addr, wdata, mem_ready, mem_rdata,
        output busy, done, rdata, bus_err, misalign,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        output start, is_store, funct3, addr, wdata, mem_ready, mem_rdata,
        input  busy, done, rdata, bus_err, misalign,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle RV32I load/store stage with handshaked data-memory port
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned half/word accesses instead of forcing alignment)
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : load_store_unit_if.master (core request/response and data-memory bus)
// Parameters:
//   TIMEOUT_CYCLES : ACCESS cycles allowed before a bus error (0 = never time out)
//   ADDR_W         : byte address width
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    state_t            r_state;
    state_t            w_next;
    logic              r_is_store;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_rdata;
    logic              r_bus_err;
    logic              r_misalign;
    logic              r_mem_req;

    logic              w_legal;
    logic              w_misalign_in;
    logic              w_timeout;
    logic [1:0]        w_off;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_fmt;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_rep;

    // Request legality is judged on the live inputs so the IDLE decision
    // and the capture happen on the same edge.
    always_comb begin
        w_legal = 1'b0;
        if (bus.is_store) begin
            w_legal = (bus.funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            w_legal = (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
    end

`ifdef MISALIGN_TRAP_EN
    // funct3[1:0] is 01 for LH/LHU/SH and 10 for LW/SW.
    assign w_misalign_in = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                           ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
    // Without the trap, lane selection below only looks at the offset bits
    // that matter for the width, which forces the access aligned.
    assign w_misalign_in = 1'b0;
`endif

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (w_legal && !w_misalign_in) ? S_ACCESS : S_DONE;
                end
            end
            S_ACCESS: begin
                if (bus.mem_ready || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Load lane extraction from the captured byte offset.
    assign w_off  = r_addr[1:0];
    assign w_byte = bus.mem_rdata[{w_off, 3'b000} +: 8];
    assign w_half = bus.mem_rdata[{w_off[1], 4'b0000} +: 16];

    always_comb begin
        w_load_fmt = bus.mem_rdata;
        case (r_funct3)
            3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_fmt = {24'h0, w_byte};
            3'b101:  w_load_fmt = {16'h0, w_half};
            default: w_load_fmt = bus.mem_rdata;
        endcase
    end

    always_comb begin
        w_be        = 4'b1111;
        w_wdata_rep = r_wdata;
        if (r_is_store) begin
            case (r_funct3[1:0])
                2'b00: begin
                    w_be        = 4'b0001 << w_off;
                    w_wdata_rep = {4{r_wdata[7:0]}};
                end
                2'b01: begin
                    w_be        = 4'b0011 << {w_off[1], 1'b0};
                    w_wdata_rep = {2{r_wdata[15:0]}};
                end
                default: begin
                    w_be        = 4'b1111;
                    w_wdata_rep = r_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_store <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_cnt      <= '0;
            r_rdata    <= 32'h0;
            r_bus_err  <= 1'b0;
            r_misalign <= 1'b0;
            r_mem_req  <= 1'b0;
        end else begin
            r_mem_req <= (w_next == S_ACCESS);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_is_store <= bus.is_store;
                        r_funct3   <= bus.funct3;
                        r_addr     <= bus.addr;
                        r_wdata    <= bus.wdata;
                        r_cnt      <= '0;
                        r_bus_err  <= !w_legal;
                        r_misalign <= w_legal && w_misalign_in;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (bus.mem_ready) begin
                        // Stores leave the previous load result visible.
                        if (!r_is_store) begin
                            r_rdata <= w_load_fmt;
                        end
                    end else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.rdata     = r_rdata;
    assign bus.bus_err   = r_bus_err;
    assign bus.misalign  = r_misalign;
    // Bus fields are only driven while the request is up so they read 0 otherwise.
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_req & r_is_store;
    assign bus.mem_be    = r_mem_req ? w_be : 4'b0000;
    assign bus.mem_addr  = r_mem_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_wdata = r_mem_req ? w_wdata_rep : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard testbench for load_store_unit
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(
        .TIMEOUT_CYCLES(16),
        .ADDR_W        (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        chk_rdata;
        logic [31:0] rdata;
        logic        bus_err;
        logic        misalign;
        int          lat;
        int          reqs;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   chk = 0;
    int   err = 0;
    int   cyc = 0;
    int   issue_cyc = 0;
    int   req_seen = 0;
    int   ready_delay = 0;
    int   rsp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [3:0] be, input logic we,
                                input logic [31:0] wd, input logic cr, input logic [31:0] rd,
                                input logic be_err, input logic mis, input int lat, input int reqs);
        exp_t e;
        e.addr = a; e.be = be; e.we = we; e.wdata = wd; e.chk_rdata = cr; e.rdata = rd;
        e.bus_err = be_err; e.misalign = mis; e.lat = lat; e.reqs = reqs;
        return e;
    endfunction

    // Memory responder: ready goes high after ready_delay request cycles (-1 = never).
    always @(negedge clk) begin
        if (rst || !bus.mem_req) begin
            rsp_cnt = 0;
            bus.mem_ready = 1'b0;
        end else begin
            bus.mem_ready = (ready_delay >= 0) && (rsp_cnt >= ready_delay);
            rsp_cnt++;
        end
    end

    // Monitor: bus fields every request cycle, response on done.
    always @(negedge clk) begin
        if (rst) begin
            req_seen = 0;
        end else begin
            if (bus.mem_req) begin
                req_seen++;
                check("busy_in_access", {31'h0, bus.busy}, 32'h1);
                if (exp_q.size() == 0) begin
                    chk++; err++;
                    $display("FAIL unexpected_mem_req: got addr 0x%08h expected no request", bus.mem_addr);
                end else begin
                    check("mem_addr", bus.mem_addr, exp_q[0].addr);
                    check("mem_be", {28'h0, bus.mem_be}, {28'h0, exp_q[0].be});
                    check("mem_we", {31'h0, bus.mem_we}, {31'h0, exp_q[0].we});
                    check("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
                end
            end
            if (bus.done) begin
                check("busy_in_done", {31'h0, bus.busy}, 32'h1);
                if (exp_q.size() == 0) begin
                    chk++; err++;
                    $display("FAIL unexpected_done: got done=1 expected no response");
                end else begin
                    m_e = exp_q.pop_front();
                    if (m_e.chk_rdata) check("rdata", bus.rdata, m_e.rdata);
                    check("bus_err", {31'h0, bus.bus_err}, {31'h0, m_e.bus_err});
                    check("misalign", {31'h0, bus.misalign}, {31'h0, m_e.misalign});
                    check("latency", 32'(cyc - issue_cyc), 32'(m_e.lat));
                    check("req_cycles", 32'(req_seen), 32'(m_e.reqs));
                end
                req_seen = 0;
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] mrd, input int dly,
                         input exp_t e, input bit poke);
        int n;
        ready_delay   = dly;
        bus.mem_rdata = mrd;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b1; bus.is_store = st; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
        issue_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        if (poke) begin
            // A start while busy must be dropped.
            @(negedge clk);
            bus.start = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b010;
            @(negedge clk);
            bus.start = 1'b0;
        end
        n = 0;
        while (!bus.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            chk++; err++;
            $display("FAIL done_wait: got no done within 60 cycles expected done");
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'b000;
        bus.addr = 32'h0; bus.wdata = 32'h0; bus.mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_bus_err", {31'h0, bus.bus_err}, 32'h0);
        check("rst_misalign", {31'h0, bus.misalign}, 32'h0);
        check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        check("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        rst = 1'b0;

        issue(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
              mk(32'h100, 4'hF, 0, 32'h0, 1, 32'hDEADBEEF, 0, 0, 2, 1), 0);
        issue(0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0,
              mk(32'h100, 4'hF, 0, 32'h0, 1, 32'hFFFFFF80, 0, 0, 2, 1), 0);
        issue(0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 0,
              mk(32'h100, 4'hF, 0, 32'h0, 1, 32'h00000080, 0, 0, 2, 1), 0);
        issue(0, 3'b001, 32'h102, 32'h0, 32'h80011234, 0,
              mk(32'h100, 4'hF, 0, 32'h0, 1, 32'hFFFF8001, 0, 0, 2, 1), 0);
        issue(0, 3'b101, 32'h100, 32'h0, 32'h80011234, 0,
              mk(32'h100, 4'hF, 0, 32'h0, 1, 32'h00001234, 0, 0, 2, 1), 0);
        issue(1, 3'b000, 32'h202, 32'h12345678, 32'h0, 0,
              mk(32'h200, 4'b0100, 1, 32'h78787878, 0, 32'h0, 0, 0, 2, 1), 0);
        issue(1, 3'b001, 32'h206, 32'hAABBCCDD, 32'h0, 0,
              mk(32'h204, 4'b1100, 1, 32'hCCDDCCDD, 0, 32'h0, 0, 0, 2, 1), 0);
        issue(0, 3'b010, 32'h10C, 32'h0, 32'hCAFEF00D, 5,
              mk(32'h10C, 4'hF, 0, 32'h0, 1, 32'hCAFEF00D, 0, 0, 7, 6), 1);
        issue(0, 3'b010, 32'h110, 32'h0, 32'h11111111, -1,
              mk(32'h110, 4'hF, 0, 32'h0, 1, 32'hCAFEF00D, 1, 0, 17, 16), 0);
        issue(0, 3'b011, 32'h120, 32'h0, 32'h22222222, 0,
              mk(32'h0, 4'h0, 0, 32'h0, 1, 32'hCAFEF00D, 1, 0, 1, 0), 0);
        issue(1, 3'b100, 32'h124, 32'h55555555, 32'h22222222, 0,
              mk(32'h0, 4'h0, 0, 32'h0, 1, 32'hCAFEF00D, 1, 0, 1, 0), 0);
`ifdef MISALIGN_TRAP_EN
        issue(1, 3'b010, 32'h101, 32'h01020304, 32'h0, 0,
              mk(32'h0, 4'h0, 0, 32'h0, 1, 32'hCAFEF00D, 0, 1, 1, 0), 0);
        issue(0, 3'b001, 32'h101, 32'h0, 32'h5678ABCD, 0,
              mk(32'h0, 4'h0, 0, 32'h0, 1, 32'hCAFEF00D, 0, 1, 1, 0), 0);
`else
        issue(1, 3'b010, 32'h101, 32'h01020304, 32'h0, 0,
              mk(32'h100, 4'hF, 1, 32'h01020304, 0, 32'h0, 0, 0, 2, 1), 0);
        issue(0, 3'b001, 32'h101, 32'h0, 32'h5678ABCD, 0,
              mk(32'h100, 4'hF, 0, 32'h0, 1, 32'hFFFFABCD, 0, 0, 2, 1), 0);
`endif

        // Reset during the third ACCESS cycle.
        ready_delay = -1;
        exp_q.push_back(mk(32'h300, 4'hF, 0, 32'h0, 1, 32'h0, 0, 0, 0, 0));
        @(negedge clk);
        bus.start = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h300; bus.wdata = 32'h0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_mem_req", {31'h0, bus.mem_req}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        check("async_rst_busy", {31'h0, bus.busy}, 32'h0);
        check("async_rst_done", {31'h0, bus.done}, 32'h0);
        check("async_rst_rdata", bus.rdata, 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue(0, 3'b010, 32'h300, 32'h0, 32'h0BADF00D, 0,
              mk(32'h300, 4'hF, 0, 32'h0, 1, 32'h0BADF00D, 0, 0, 2, 1), 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
